// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: blank pattern,
// active-low hex segment table and scan FSM state encoding.
package display_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_hex7seg_dec.sv
// Purely combinational nibble to active-low 7-segment decoder (full hex).
module hex7seg_dec
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blank slots and double-buffered digits.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zeros on digits above digit 0.
module display_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start,
    output logic                  pending
);
    import display_scan_ctrl_pkg::*;

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int DW    = 4 * N_DIGITS;

    scan_state_t         state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [PRE_W-1:0]    presc_reg, presc_next;
    logic [DW-1:0]       shadow_reg, shadow_next;
    logic [DW-1:0]       active_reg, active_next;
    logic                pending_reg, pending_next;
    logic [6:0]          seg_reg, seg_next;
    logic [N_DIGITS-1:0] an_reg, an_next;
    logic                frame_start_reg, frame_start_next;
    logic                boundary;
    logic [3:0]          nibble_sel;
    logic [6:0]          dec_seg;
    logic                lz_blank;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        presc_next = presc_reg;
        if (!en) begin
            state_next = S_IDLE;
            idx_next   = '0;
            presc_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_BLANK;
                    idx_next   = '0;
                    presc_next = '0;
                end
                S_BLANK: begin
                    state_next = S_DRIVE;
                    presc_next = PRE_W'(1);
                end
                S_DRIVE: begin
                    if (presc_reg == PRE_W'(REFRESH_DIV - 1)) begin
                        state_next = S_BLANK;
                        presc_next = '0;
                        idx_next   = (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                    presc_next = '0;
                end
            endcase
        end
    end

    assign boundary = (state_next == S_BLANK) && (idx_next == '0);

    // A load on the boundary (or while idle) must reach active directly and
    // also refresh shadow, otherwise the next boundary would restore stale data.
    always_comb begin
        shadow_next  = shadow_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        if (boundary) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
        end
        if (load) begin
            shadow_next = digits;
            if (boundary || state_reg == S_IDLE) begin
                active_next  = digits;
                pending_next = 1'b0;
            end else begin
                pending_next = 1'b1;
            end
        end
    end

    always_comb begin
        nibble_sel = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) nibble_sel = active_next[4*i +: 4];
        end
    end

    hex7seg_dec u_dec (
        .nibble (nibble_sel),
        .seg    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] nib_zero;
    logic [N_DIGITS-1:0] zero_above;
    logic                zero_run;

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib_zero
        assign nib_zero[gi] = (active_next[4*gi +: 4] == 4'h0);
    end

    // zero_above[i]: nibble i and every higher nibble are zero.
    always_comb begin
        zero_run   = 1'b1;
        zero_above = '0;
        lz_blank   = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & nib_zero[i];
            zero_above[i] = zero_run;
        end
        for (int i = 1; i < N_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) lz_blank = zero_above[i];
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_next         = SEG_BLANK;
        an_next          = '1;
        frame_start_next = boundary;
        if (state_next == S_DRIVE) begin
            an_next  = ~(N_DIGITS'(1) << idx_next);
            seg_next = lz_blank ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            presc_reg       <= '0;
            shadow_reg      <= '0;
            active_reg      <= '0;
            pending_reg     <= 1'b0;
            seg_reg         <= SEG_BLANK;
            an_reg          <= '1;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            presc_reg       <= presc_next;
            shadow_reg      <= shadow_next;
            active_reg      <= active_next;
            pending_reg     <= pending_next;
            seg_reg         <= seg_next;
            an_reg          <= an_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign seg         = seg_reg;
    assign an          = an_reg;
    assign frame_start = frame_start_reg;
    assign pending     = pending_reg;

endmodule
